// File: rtl/snd_mmc5_if.sv
// CPU-side bus for the MMC5 sound core: snooped cycle in, read data and IRQ back to the mapper.
interface snd_mmc5_if;
  logic        cpu_tick;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic [7:0]  snd_dout;
  logic        snd_oe;
  logic        snd_irq;

  modport master (output cpu_tick, cpu_rw, cpu_addr, cpu_dat, input snd_dout, snd_oe, snd_irq);
  modport slave  (input cpu_tick, cpu_rw, cpu_addr, cpu_dat, output snd_dout, snd_oe, snd_irq);
endinterface

// File: rtl/snd_mmc5_core.sv
// MMC5 expansion audio: two sweepless pulse channels plus an 8-bit PCM channel mixed to 10 bits.
// Define SND_MMC5_PCM_EN to build the PCM channel ($5010/$5011, read-mode capture, IRQ).
module snd_mmc5_core #(
  parameter int QFRAME_DIV = 7457
) (
  input  logic       clk,
  input  logic       map_rst,
  snd_mmc5_if.slave  bus,
  output logic [9:0] vol
);
  localparam int NUM_LANES = 2;
  localparam logic [7:0] LEN_TAB [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,  8'd160, 8'd8,  8'd60, 8'd10,
    8'd14, 8'd12,  8'd26, 8'd14, 8'd12, 8'd16, 8'd24, 8'd18, 8'd48,  8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30};
  // Indexed by duty, then bit [7-step]: step 0 is the MSB.
  localparam logic [3:0][7:0] DUTY_TAB = {8'b10011111, 8'b01111000, 8'b01100000, 8'b01000000};

  logic        wr;
  logic [15:0] addr;
  logic [7:0]  dat;
  assign wr   = bus.cpu_tick & ~bus.cpu_rw;
  assign addr = bus.cpu_addr;
  assign dat  = bus.cpu_dat;

  logic                 half, qtick;
  logic [12:0]          fcnt;
  logic [NUM_LANES-1:0] en;
  assign qtick = (fcnt == 13'(QFRAME_DIV - 1));

  always_ff @(posedge clk) begin
    if (map_rst) begin
      half <= 1'b0;
      fcnt <= '0;
      en   <= '0;
    end else if (bus.cpu_tick) begin
      half <= ~half;
      fcnt <= qtick ? '0 : fcnt + 13'd1;
      if (wr && addr == 16'h5015) en <= dat[NUM_LANES-1:0];
    end
  end

  logic [NUM_LANES-1:0][3:0] p_out;
  logic [NUM_LANES-1:0]      len_nz;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pulse
    localparam logic [15:0] BASE = 16'h5000 + 16'(4 * g);
    logic [1:0]  duty;
    logic        halt, cvol, estart;
    logic [3:0]  vpar, decay, ediv;
    logic [10:0] period, tcnt;
    logic [2:0]  step;
    logic [7:0]  len;

    // Clock-driven updates come first so that register writes in the same tick override them.
    always_ff @(posedge clk) begin
      if (map_rst) begin
        {duty, halt, cvol, vpar} <= '0;
        period <= '0;
        tcnt   <= '0;
        step   <= '0;
        len    <= '0;
        estart <= 1'b0;
        decay  <= '0;
        ediv   <= '0;
      end else if (bus.cpu_tick) begin
        if (half) begin
          if (tcnt == '0) begin
            tcnt <= period;
            step <= step + 3'd1;
          end else tcnt <= tcnt - 11'd1;
        end
        if (qtick) begin
          if (estart) begin
            estart <= 1'b0;
            decay  <= 4'd15;
            ediv   <= vpar;
          end else if (ediv == '0) begin
            ediv <= vpar;
            if (decay != '0) decay <= decay - 4'd1;
            else if (halt)   decay <= 4'd15;
          end else ediv <= ediv - 4'd1;
          if (len != '0 && !halt) len <= len - 8'd1;
        end
        if (wr && addr == BASE)          {duty, halt, cvol, vpar} <= dat;
        if (wr && addr == BASE + 16'd2)  period[7:0] <= dat;
        if (wr && addr == BASE + 16'd3) begin
          period[10:8] <= dat[2:0];
          step         <= '0;
          estart       <= 1'b1;
          if (en[g]) len <= LEN_TAB[dat[7:3]];
        end
        if (wr && addr == 16'h5015 && !dat[g]) len <= '0;
      end
    end

    assign p_out[g]  = (len == '0 || period < 11'd8 || !DUTY_TAB[duty][3'd7 - step]) ? 4'd0
                     : (cvol ? vpar : decay);
    assign len_nz[g] = (len != '0);
  end

  logic [7:0] pcm, st5010;
  logic       pcm_irq;

`ifdef SND_MMC5_PCM_EN
  logic rd, pcm_mode, pcm_irq_en, pcm_pend, cap;
  assign rd  = bus.cpu_tick & bus.cpu_rw;
  // Write mode samples $5011 writes; read mode samples ROM data fetched from $8000-$BFFF.
  assign cap = (wr && addr == 16'h5011 && !pcm_mode) || (rd && pcm_mode && addr[15:14] == 2'b10);

  always_ff @(posedge clk) begin
    if (map_rst) begin
      pcm        <= '0;
      pcm_mode   <= 1'b0;
      pcm_irq_en <= 1'b0;
      pcm_pend   <= 1'b0;
    end else if (bus.cpu_tick) begin
      if (wr && addr == 16'h5010) begin
        pcm_mode   <= dat[0];
        pcm_irq_en <= dat[7];
      end
      if (rd && addr == 16'h5010) pcm_pend <= 1'b0;
      if (cap) begin
        if (dat != '0) pcm <= dat;
        else           pcm_pend <= 1'b1;
      end
    end
  end

  assign pcm_irq = pcm_pend & pcm_irq_en;
  assign st5010  = {pcm_pend, 7'd0};
`else
  assign pcm     = '0;
  assign pcm_irq = 1'b0;
  assign st5010  = '0;
`endif

  logic sel10, sel15;
  assign sel10        = bus.cpu_rw && addr == 16'h5010;
  assign sel15        = bus.cpu_rw && addr == 16'h5015;
  assign bus.snd_oe   = sel10 | sel15;
  assign bus.snd_dout = sel15 ? {6'd0, len_nz} : (sel10 ? st5010 : 8'd0);
  assign bus.snd_irq  = pcm_irq;

  logic [4:0] psum;
  assign psum = 5'(p_out[0]) + 5'(p_out[1]);

  always_ff @(posedge clk) begin
    if (map_rst) vol <= '0;
    else         vol <= {1'b0, psum, 4'd0} + {2'd0, pcm};
  end
endmodule

// File: tb/tb_snd_mmc5_core.sv
// Bench for snd_mmc5_core: behavioural channel model checked every cycle, plus directed literal checks.
module tb_snd_mmc5_core;
  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       map_rst = 1'b1;
  logic [9:0] vol;
  snd_mmc5_if bus();

  snd_mmc5_core #(.QFRAME_DIV(Q)) dut (.clk(clk), .map_rst(map_rst), .bus(bus), .vol(vol));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int LEN_T[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                    12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int DUTY[4][8] = '{'{0,1,0,0,0,0,0,0}, '{0,1,1,0,0,0,0,0},
                     '{0,1,1,1,1,0,0,0}, '{1,0,0,1,1,1,1,1}};
  int m_duty[2], m_halt[2], m_cvol[2], m_v[2], m_period[2], m_tcnt[2], m_step[2];
  int m_len[2], m_en[2], m_start[2], m_decay[2], m_div[2];
  int m_ticks, m_fcnt, m_qcount = 0;
  int m_pcm, m_mode, m_irqen, m_pend;
  int exp_vol = 0;

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_halt[c] = 0; m_cvol[c] = 0; m_v[c] = 0; m_period[c] = 0; m_tcnt[c] = 0;
      m_step[c] = 0; m_len[c] = 0; m_en[c] = 0; m_start[c] = 0; m_decay[c] = 0; m_div[c] = 0;
    end
    m_ticks = 0; m_fcnt = 0; m_pcm = 0; m_mode = 0; m_irqen = 0; m_pend = 0;
  endtask

  function automatic int m_level(int c);
    if (m_len[c] == 0 || m_period[c] < 8 || DUTY[m_duty[c]][m_step[c]] == 0) return 0;
    return (m_cvol[c] != 0) ? m_v[c] : m_decay[c];
  endfunction

  task automatic m_cap(input int d);
    if (d != 0) m_pcm = d; else m_pend = 1;
  endtask

  // One CPU tick: timers/sequencer act on the pre-tick state, then the bus access lands on top.
  task automatic m_tick(input logic rw, input logic [15:0] a, input logic [7:0] d);
    bit hc, q;
    hc = (m_ticks % 2) == 1;
    m_ticks++;
    q = (m_fcnt == Q - 1);
    m_fcnt = q ? 0 : m_fcnt + 1;
    if (q) m_qcount++;
    for (int c = 0; c < 2; c++) begin
      if (hc) begin
        if (m_tcnt[c] == 0) begin m_tcnt[c] = m_period[c]; m_step[c] = (m_step[c] + 1) % 8; end
        else m_tcnt[c]--;
      end
      if (q) begin
        if (m_start[c] != 0) begin m_start[c] = 0; m_decay[c] = 15; m_div[c] = m_v[c]; end
        else if (m_div[c] == 0) begin
          m_div[c] = m_v[c];
          if (m_decay[c] > 0) m_decay[c]--;
          else if (m_halt[c] != 0) m_decay[c] = 15;
        end else m_div[c]--;
        if (m_len[c] > 0 && m_halt[c] == 0) m_len[c]--;
      end
    end
    if (!rw) begin
      for (int c = 0; c < 2; c++) begin
        if (a == 16'h5000 + 16'(4*c)) begin
          m_duty[c] = d[7:6]; m_halt[c] = d[5]; m_cvol[c] = d[4]; m_v[c] = d[3:0];
        end
        if (a == 16'h5002 + 16'(4*c)) m_period[c] = (m_period[c] & 'h700) | d;
        if (a == 16'h5003 + 16'(4*c)) begin
          m_period[c] = (m_period[c] & 'hFF) | (int'(d[2:0]) << 8);
          m_step[c] = 0; m_start[c] = 1;
          if (m_en[c] != 0) m_len[c] = LEN_T[d[7:3]];
        end
        if (a == 16'h5015) begin m_en[c] = d[c]; if (!d[c]) m_len[c] = 0; end
      end
`ifdef SND_MMC5_PCM_EN
      if (a == 16'h5010) begin m_mode = d[0]; m_irqen = d[7]; end
      if (a == 16'h5011 && m_mode == 0) m_cap(d);
`endif
    end else begin
`ifdef SND_MMC5_PCM_EN
      if (a == 16'h5010) m_pend = 0;
      if (a >= 16'h8000 && a <= 16'hBFFF && m_mode != 0) m_cap(d);
`endif
    end
  endtask

  always @(posedge clk) begin
    if (map_rst) begin m_reset(); exp_vol = 0; end
    else begin
      exp_vol = (m_level(0) + m_level(1)) * 16 + m_pcm;
      if (bus.cpu_tick) m_tick(bus.cpu_rw, bus.cpu_addr, bus.cpu_dat);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      int e_oe, e_dout, e_irq;
      e_oe   = bus.cpu_rw && (bus.cpu_addr == 16'h5010 || bus.cpu_addr == 16'h5015);
      e_dout = 0;
      if (bus.cpu_rw && bus.cpu_addr == 16'h5015) e_dout = ((m_len[1] != 0) << 1) | (m_len[0] != 0);
      if (bus.cpu_rw && bus.cpu_addr == 16'h5010) e_dout = m_pend << 7;
      e_irq  = m_pend & m_irqen;
      chk("vol", vol, exp_vol);
      chk("snd_oe", bus.snd_oe, e_oe);
      chk("snd_dout", bus.snd_dout, e_dout);
      chk("snd_irq", bus.snd_irq, e_irq);
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input logic t, input logic rw, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    bus.cpu_tick = t; bus.cpu_rw = rw; bus.cpu_addr = a; bus.cpu_dat = d;
  endtask
  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d); cyc(1'b1, 1'b0, a, d); endtask
  task automatic idle(input int n); repeat (n) cyc(1'b1, 1'b1, 16'h4000, 8'h00); endtask
  task automatic do_reset();
    @(negedge clk); #1;
    map_rst = 1'b1; bus.cpu_tick = 1'b0;
    repeat (2) @(negedge clk);
    #1 map_rst = 1'b0;
  endtask

  initial begin
    int q0, n, run, first_run, rise1, rise2, bad, prev, r;
    logic t, rw;
    logic [15:0] a;
    logic [7:0] d;
    bus.cpu_tick = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = '0; bus.cpu_dat = '0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    do_reset();
    chk("rst_vol", vol, 0);
    chk("rst_irq", bus.snd_irq, 0);

    // Long idle stays silent
    idle(20000);
    cyc(1'b1, 1'b1, 16'h5015, 8'h00); #1;
    chk("idle_5015", bus.snd_dout, 8'h00);
    chk("idle_vol", vol, 0);

    // Constant-volume pulse, duty index 2, period 0x40
    wr_reg(16'h5015, 8'h01); wr_reg(16'h5000, 8'hBF); wr_reg(16'h5002, 8'h40); wr_reg(16'h5003, 8'h08);
    run = 0; first_run = -1; rise1 = -1; rise2 = -1; bad = 0; prev = 0;
    for (int i = 0; i < 2300; i++) begin
      idle(1); #1;
      if (vol != 0 && vol != 240) bad++;
      if (vol == 240 && prev == 0) begin if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i; end
      if (vol == 240) run++;
      else begin if (run > 0 && first_run < 0) first_run = run; run = 0; end
      prev = int'(vol);
    end
    chk("pulse_levels", bad, 0);
    chk("pulse_hi_run", first_run, 520);
    chk("pulse_period", rise2 - rise1, 1040);
    do_reset();
    chk("midnote_rst_vol", vol, 0);

    // Length counter expiry (len index 3 = 2)
    wr_reg(16'h5000, 8'h0F); wr_reg(16'h5015, 8'h01); wr_reg(16'h5003, 8'h18);
    cyc(1'b1, 1'b1, 16'h5015, 8'h00); #1;
    chk("len_start_5015", bus.snd_dout, 8'h01);
    q0 = m_qcount; n = 0;
    while (m_qcount < q0 + 2 && n < 4 * Q) begin idle(1); n++; end
    chk("len_qt_wait", m_qcount - q0, 2);
    chk("len_model", m_len[0], 0);
    cyc(1'b1, 1'b1, 16'h5015, 8'h00); #1;
    chk("len_end_5015", bus.snd_dout, 8'h00);

    // Envelope decay, divider 2, no loop
    do_reset();
    wr_reg(16'h5015, 8'h01); wr_reg(16'h5000, 8'h02); wr_reg(16'h5002, 8'hFF); wr_reg(16'h5003, 8'h08);
    idle(1);
    q0 = m_qcount; n = 0;
    while (m_qcount < q0 + 16 && n < 20 * Q) begin idle(1); n++; end
    chk("env_qt_wait", m_qcount - q0, 16);
    chk("env_decay10", m_decay[0], 10);
    while (m_qcount < q0 + 61 && n < 70 * Q) begin idle(1); n++; end
    chk("env_decay0", m_decay[0], 0);

    // Length reload on the same tick as a length clock
    do_reset();
    wr_reg(16'h5015, 8'h01); wr_reg(16'h5000, 8'h8F); wr_reg(16'h5002, 8'h80);
    idle(1); n = 0;
    while (m_fcnt != Q - 2 && n < 2 * Q) begin idle(1); n++; end
    chk("fcnt_align", m_fcnt, Q - 2);
    wr_reg(16'h5003, 8'h08);
    idle(1);
    chk("same_tick_wrap", m_fcnt, 0);
    chk("same_tick_len", m_len[0], 254);
    n = 0;
    do begin cyc(1'b1, 1'b1, 16'h5015, 8'h00); #1; n++; end
    while (bus.snd_dout[0] && n < 260 * Q);
    chk("len254_ticks", n, 254 * Q);

    // PCM channel
    do_reset();
    wr_reg(16'h5010, 8'h80); wr_reg(16'h5011, 8'h55); idle(2);
`ifdef SND_MMC5_PCM_EN
    chk("pcm_vol", vol, 10'h055);
    wr_reg(16'h5011, 8'h00); idle(1);
    chk("pcm_irq_set", bus.snd_irq, 1);
    chk("pcm_vol_hold", vol, 10'h055);
    cyc(1'b1, 1'b1, 16'h5010, 8'h00); #1;
    chk("pcm_5010_rd", bus.snd_dout, 8'h80);
    idle(1);
    chk("pcm_irq_clr", bus.snd_irq, 0);
`else
    chk("nopcm_vol", vol, 0);
    cyc(1'b1, 1'b1, 16'h5010, 8'h00); #1;
    chk("nopcm_5010_rd", bus.snd_dout, 8'h00);
    chk("nopcm_5010_oe", bus.snd_oe, 1);
`endif

    // Randomized traffic, with a reset in the middle
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if (i == 10000) begin do_reset(); chk("rand_rst_vol", vol, 0); end
      r = $urandom_range(0, 99);
      t = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      rw = 1'b1;
      a = 16'($urandom_range(0, 16'h7FFF));
      if (r < 8) begin
        rw = 1'b0;
        a = 16'h5000 + 16'($urandom_range(0, 1) * 4 + $urandom_range(0, 3));
        if (a[1:0] == 2'd3) d[2:0] = 3'($urandom_range(0, 1));
      end else if (r < 10) begin rw = 1'b0; a = 16'h5015; d = 8'($urandom_range(0, 3));
      end else if (r < 12) begin rw = 1'b0; a = 16'h5010;
      end else if (r < 15) begin rw = 1'b0; a = 16'h5011; if ($urandom_range(0, 3) == 0) d = 8'h00;
      end else if (r < 22) begin
        a = 16'($urandom_range(16'h8000, 16'hBFFF)); if ($urandom_range(0, 7) == 0) d = 8'h00;
      end else if (r < 26) a = 16'h5010;
      else if (r < 30) a = 16'h5015;
      cyc(t, rw, a, d);
    end

    cyc(1'b0, 1'b1, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
